ddr_word_tx: RTL and testbench
==============================

DDR_WORD_TX -- requirements
Module: ddr_word_tx

Interface
REQ-001 SHALL have parameter DATA_W, default 16, meaning payload bits per word; even, >=2.
REQ-002 SHALL have parameter CNT_W, default 8, meaning width of the data-word count.
REQ-003 SHALL have port i_sys_clk  in  1  system clock; all logic on rising edge.
REQ-004 SHALL have port i_sys_rst  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port i_sclgen_scl_pos_edge  in  1  one-cycle strobe marking an SCL rising edge.
REQ-006 SHALL have port i_sclgen_scl_neg_edge  in  1  one-cycle strobe marking an SCL falling edge.
REQ-007 SHALL have port i_tx_start  in  1  frame start request.
REQ-008 SHALL have port i_tx_cmd  in  DATA_W  command word payload.
REQ-009 SHALL have port i_tx_word_cnt  in  CNT_W  number of data words following the command.
REQ-010 SHALL have port i_tx_abort  in  1  synchronous frame abort.
REQ-011 SHALL have port i_regf_data  in  DATA_W  next data word.
REQ-012 SHALL have port i_regf_valid  in  1  i_regf_data is valid.
REQ-013 SHALL have port o_regf_ready  out  1  one-cycle pulse; data word consumed.
REQ-014 SHALL have port o_sdahnd_serial_data  out  1  serial bit to the SDA handler.
REQ-015 SHALL have port o_sclgen_stall  out  1  requests the SCL generator to hold SCL.
REQ-016 SHALL have port o_tx_busy  out  1  frame in progress.
REQ-017 SHALL have port o_tx_done  out  1  one-cycle pulse at normal frame completion.

Function
REQ-018 SHALL run an FSM with states IDLE, CMD, DATA, CRC and FIN; IDLE goes to CMD when i_tx_start=1, CMD and DATA go to DATA while words remain, otherwise to CRC, CRC goes to FIN, and FIN goes to IDLE.
REQ-019 SHALL sample i_tx_start, i_tx_cmd and i_tx_word_cnt only in IDLE, assert o_tx_busy on the next cycle, and ignore i_tx_start while busy.
REQ-020 SHALL shift one frame bit onto o_sdahnd_serial_data, registered, in the cycle after each edge strobe while busy; coincident pos and neg strobes SHALL count as one edge.
REQ-021 SHALL build the command word, DATA_W+4 bits MSB-first, as preamble 2'b01, then i_tx_cmd, then P1, then P0.
REQ-022 SHALL build each data word, DATA_W+4 bits, as preamble 2'b10, then the data payload, then P1, then P0.
REQ-023 SHALL compute parity as P1 = XOR of the odd-index payload bits and P0 = (XOR of the even-index payload bits) XOR 1.
REQ-024 SHALL load a data word at the strobe that would drive its first preamble bit and pulse o_regf_ready in that cycle; when i_regf_valid=0 at that strobe, the block SHALL ignore the strobe, hold the line, and assert o_sclgen_stall until i_regf_valid=1.
REQ-025 SHALL go from CMD directly to FIN when i_tx_word_cnt=0, sending no data word and no CRC word.
REQ-026 SHALL count data words in CNT_W bits with no wrap-around; a count of 2^CNT_W-1 SHALL send exactly that many words.
REQ-027 SHALL, in FIN, hold the last bit for one more edge; on the following strobe it SHALL drive the line to 1, drop o_tx_busy, and pulse o_tx_done.
REQ-028 SHALL, on i_tx_abort=1 while busy, go to IDLE on the next cycle with line=1, busy=0, stall=0, and no o_tx_done; abort SHALL take priority over a simultaneous strobe.

Reset
REQ-029 SHALL, while i_sys_rst=0 (including mid-frame), force the FSM to IDLE, o_sdahnd_serial_data=1, and o_regf_ready, o_sclgen_stall, o_tx_busy, o_tx_done, all counters and CRC to 0.
REQ-030 SHALL ignore the edge strobes during reset; the first frame SHALL require a new i_tx_start after release.

Configuration
REQ-031 SHALL implement macro DDR_TX_CRC_EN; when defined, a CRC word SHALL follow the last data word (cnt>0): 2'b01, token 4'b1100, CRC5 MSB-first, 1'b1, 12 bits in total.
REQ-032 SHALL compute CRC5 with polynomial x^5+x^2+1 and seed 5'b11111, MSB-first over data payload bits only, re-seeded at each frame start.
REQ-033 SHALL, when DDR_TX_CRC_EN is undefined, contain no CRC state or logic, omit the CRC state, and go from the last data word to FIN.

Verification
REQ-034 SHALL cover: cmd=16'h8066, cnt=0 -> 20 bits 01_1000000001100110_11, o_tx_done on the 21st strobe, no o_regf_ready.
REQ-035 SHALL cover (macro defined): cmd=16'h8066, cnt=1, data=16'h0000 -> 20 cmd bits, then 10_0000000000000000_01, then CRC word 01_1100_00001_1, then o_tx_done.
REQ-036 SHALL cover: the same as REQ-035 with i_regf_valid low for 10 cycles at the data-word load -> o_sclgen_stall high for those cycles, line held, identical bit sequence.
REQ-037 SHALL cover: i_tx_abort at the 5th data-word bit -> next cycle line=1, busy=0, no o_tx_done; a new start sends a correct frame with CRC re-seeded.
REQ-038 SHALL cover: i_sys_rst low mid command word -> all outputs take their reset values immediately and no bits are shifted until a new i_tx_start.
REQ-039 SHALL cover (macro undefined): cmd=16'h8066, cnt=1, data=16'h0000 -> 40 bits, o_tx_done on the 41st strobe, no CRC word.

Source files
------------

// File: rtl/ddr_word_tx.sv
// ddr_word_tx: shifts a command word and N data words onto SDA, one bit per SCL edge.
// Optional CRC trailer word is compiled in with `define DDR_TX_CRC_EN.
module ddr_word_tx #(
  parameter int DATA_W = 16,
  parameter int CNT_W  = 8
) (
  input  logic              i_sys_clk,
  input  logic              i_sys_rst,
  input  logic              i_sclgen_scl_pos_edge,
  input  logic              i_sclgen_scl_neg_edge,
  input  logic              i_tx_start,
  input  logic [DATA_W-1:0] i_tx_cmd,
  input  logic [CNT_W-1:0]  i_tx_word_cnt,
  input  logic              i_tx_abort,
  input  logic [DATA_W-1:0] i_regf_data,
  input  logic              i_regf_valid,
  output logic              o_regf_ready,
  output logic              o_sdahnd_serial_data,
  output logic              o_sclgen_stall,
  output logic              o_tx_busy,
  output logic              o_tx_done
);

  // state | meaning
  // IDLE  | line high, waiting for i_tx_start
  // CMD   | shifting the command word
  // DATA  | loading / shifting data words (bit_left==0 means next word due)
  // CRC   | shifting the CRC trailer (DDR_TX_CRC_EN only)
  // FIN   | last bit held for one edge, then line released
  localparam int FW = DATA_W + 4;
`ifdef DDR_TX_CRC_EN
  localparam int SR_W = (FW > 12) ? FW : 12;
`else
  localparam int SR_W = FW;
`endif
  localparam int BL_W = $clog2(SR_W + 1);

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    DATA,
`ifdef DDR_TX_CRC_EN
    CRC,
`endif
    FIN
  } state_t;

  state_t           state;
  logic [SR_W-1:0]  shreg;
  logic [BL_W-1:0]  bit_left;
  logic [CNT_W-1:0] word_cnt;
`ifdef DDR_TX_CRC_EN
  logic [4:0]       crc5;
`endif
  logic             stb;

  assign stb = i_sclgen_scl_pos_edge | i_sclgen_scl_neg_edge;

  function automatic logic [FW-1:0] word_fmt(input logic [1:0] pre, input logic [DATA_W-1:0] w);
    logic p1, p0;
    p1 = 1'b0;
    p0 = 1'b1;
    for (int i = 0; i < DATA_W; i++) begin
      if (i % 2 == 1) p1 = p1 ^ w[i];
      else            p0 = p0 ^ w[i];
    end
    return {pre, w, p1, p0};
  endfunction

  // words are left-aligned so the line always takes the shift register MSB
  function automatic logic [SR_W-1:0] align(input logic [FW-1:0] w);
    return SR_W'(w) << (SR_W - FW);
  endfunction

`ifdef DDR_TX_CRC_EN
  function automatic logic [4:0] crc5_upd(input logic [4:0] c, input logic [DATA_W-1:0] w);
    logic [4:0] r;
    logic       fb;
    r = c;
    for (int i = DATA_W - 1; i >= 0; i--) begin
      fb = r[4] ^ w[i];
      r  = {r[3:0], 1'b0} ^ {2'b00, fb, 1'b0, fb};
    end
    return r;
  endfunction
`endif

  always_ff @(posedge i_sys_clk or negedge i_sys_rst) begin
    if (!i_sys_rst) begin
      state                <= IDLE;
      shreg                <= '0;
      bit_left             <= '0;
      word_cnt             <= '0;
`ifdef DDR_TX_CRC_EN
      crc5                 <= '0;
`endif
      o_sdahnd_serial_data <= 1'b1;
      o_regf_ready         <= 1'b0;
      o_sclgen_stall       <= 1'b0;
      o_tx_busy            <= 1'b0;
      o_tx_done            <= 1'b0;
    end else begin
      o_regf_ready <= 1'b0;
      o_tx_done    <= 1'b0;
      if (state != IDLE && i_tx_abort) begin
        state                <= IDLE;
        bit_left             <= '0;
        word_cnt             <= '0;
        o_sdahnd_serial_data <= 1'b1;
        o_sclgen_stall       <= 1'b0;
        o_tx_busy            <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (i_tx_start) begin
              state     <= CMD;
              shreg     <= align(word_fmt(2'b01, i_tx_cmd));
              bit_left  <= BL_W'(FW);
              word_cnt  <= i_tx_word_cnt;
              o_tx_busy <= 1'b1;
`ifdef DDR_TX_CRC_EN
              crc5      <= 5'b11111;
`endif
            end
          end
          FIN: begin
            if (stb) begin
              state                <= IDLE;
              o_sdahnd_serial_data <= 1'b1;
              o_tx_busy            <= 1'b0;
              o_tx_done            <= 1'b1;
            end
          end
          default: begin
            if (bit_left == '0) begin
              // word boundary: the strobe only counts if a data word is available
              if (stb && i_regf_valid) begin
                o_sdahnd_serial_data <= 1'b1;
                shreg                <= align(word_fmt(2'b10, i_regf_data)) << 1;
                bit_left             <= BL_W'(FW - 1);
                word_cnt             <= word_cnt - CNT_W'(1);
                o_regf_ready         <= 1'b1;
                o_sclgen_stall       <= 1'b0;
`ifdef DDR_TX_CRC_EN
                crc5                 <= crc5_upd(crc5, i_regf_data);
`endif
              end else if (stb) begin
                o_sclgen_stall <= 1'b1;
              end else if (o_sclgen_stall && i_regf_valid) begin
                o_sclgen_stall <= 1'b0;
              end
            end else if (stb) begin
              o_sdahnd_serial_data <= shreg[SR_W-1];
              shreg                <= shreg << 1;
              bit_left             <= bit_left - BL_W'(1);
              if (bit_left == BL_W'(1)) begin
`ifdef DDR_TX_CRC_EN
                if (state == CRC) state <= FIN;
                else if (word_cnt != '0) state <= DATA;
                else if (state == DATA) begin
                  state    <= CRC;
                  shreg    <= SR_W'({2'b01, 4'b1100, crc5, 1'b1}) << (SR_W - 12);
                  bit_left <= BL_W'(12);
                end else state <= FIN;
`else
                if (word_cnt != '0) state <= DATA;
                else                state <= FIN;
`endif
              end
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ddr_word_tx.sv
// Directed bench for ddr_word_tx; expected frames are hand-built bit strings.
module tb_ddr_word_tx;

  logic        clk = 1'b0;
  logic        rst_n, pos, neg, start, abort, valid;
  logic [15:0] cmd, regf_data;
  logic [7:0]  word_cnt;
  logic        ready, line, stall, busy, done;

  int errors = 0;
  int checks = 0;
  int ready_cnt, widx;
  logic pol = 1'b0;
  logic [15:0] words [0:3];

  localparam logic [19:0] CMD_8066 = 20'b01_1000000001100110_11;
  localparam logic [19:0] CMD_0003 = 20'b01_0000000000000011_10;
  localparam logic [19:0] D0000    = 20'b10_0000000000000000_01;
  localparam logic [19:0] D0001    = 20'b10_0000000000000001_00;
  localparam logic [19:0] D0002    = 20'b10_0000000000000010_11;
  localparam logic [19:0] DFFFF    = 20'b10_1111111111111111_01;
  localparam logic [11:0] CRC_0000 = 12'b01_1100_00001_1;

  always #5 clk = ~clk;

  ddr_word_tx dut (
    .i_sys_clk            (clk),
    .i_sys_rst            (rst_n),
    .i_sclgen_scl_pos_edge(pos),
    .i_sclgen_scl_neg_edge(neg),
    .i_tx_start           (start),
    .i_tx_cmd             (cmd),
    .i_tx_word_cnt        (word_cnt),
    .i_tx_abort           (abort),
    .i_regf_data          (regf_data),
    .i_regf_valid         (valid),
    .o_regf_ready         (ready),
    .o_sdahnd_serial_data (line),
    .o_sclgen_stall       (stall),
    .o_tx_busy            (busy),
    .o_tx_done            (done)
  );

`ifdef DDR_TX_CRC_EN
  function automatic logic [4:0] crc_ref(input logic [4:0] c, input logic [15:0] w);
    logic [4:0] r;
    r = c;
    for (int i = 15; i >= 0; i--) begin
      if (r[4] ^ w[i]) r = {r[3:0], 1'b0} ^ 5'b00101;
      else             r = {r[3:0], 1'b0};
    end
    return r;
  endfunction
`endif

  // one edge strobe, line sampled in the cycle after it
  task automatic do_strobe(input logic both, output logic b);
    @(negedge clk);
    if (both) begin pos = 1'b1; neg = 1'b1; end
    else if (pol) pos = 1'b1;
    else neg = 1'b1;
    pol = ~pol;
    @(negedge clk);
    pos = 1'b0;
    neg = 1'b0;
    b = line;
    if (ready) begin
      ready_cnt++;
      if (widx < 3) widx++;
      regf_data = words[widx];
    end
  endtask

  task automatic run_frame(input int max_strobes, input int both_every,
                           output logic [127:0] bits, output int nbits, output int done_at);
    logic b;
    bits = '0; nbits = 0; done_at = 0;
    for (int k = 1; k <= max_strobes; k++) begin
      do_strobe(both_every > 0 && (k % both_every) == 0, b);
      if (done) begin
        done_at = k;
        break;
      end
      bits = {bits[126:0], b};
      nbits++;
    end
  endtask

  task automatic new_frame(input logic [15:0] c, input logic [7:0] n);
    ready_cnt = 0; widx = 0; regf_data = words[0]; valid = 1'b1;
    @(negedge clk);
    cmd = c; word_cnt = n; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset();
    logic b;
    rst_n = 1'b0; pos = 0; neg = 0; start = 0; abort = 0; valid = 1'b1;
    cmd = '0; word_cnt = '0; regf_data = '0;
    repeat (2) @(negedge clk);
    checks++;
    if ({line, busy, stall, ready, done} !== 5'b10000) begin
      errors++; $display("FAIL reset_outputs got %b exp 10000", {line, busy, stall, ready, done});
    end
    do_strobe(1'b0, b);
    do_strobe(1'b1, b);
    checks++;
    if ({b, busy} !== 2'b10) begin
      errors++; $display("FAIL reset_strobe_ignored got %b exp 10", {b, busy});
    end
    @(negedge clk); rst_n = 1'b1;
    do_strobe(1'b0, b);
    do_strobe(1'b0, b);
    checks++;
    if ({b, busy, done} !== 3'b100) begin
      errors++; $display("FAIL no_start_no_frame got %b exp 100", {b, busy, done});
    end
  endtask

  task automatic test_cmd_only();
    logic [127:0] bits; int nb, da;
    new_frame(16'h8066, 8'd0);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL cmd_only_busy got %b exp 1", busy); end
    run_frame(40, 0, bits, nb, da);
    checks++;
    if (nb !== 20 || bits[19:0] !== CMD_8066) begin
      errors++; $display("FAIL cmd_only_bits got %0d bits %h exp 20 bits %h", nb, bits[19:0], CMD_8066);
    end
    checks++;
    if (da !== 21 || line !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL cmd_only_done got strobe %0d line %b busy %b exp 21 1 0", da, line, busy);
    end
    checks++;
    if (ready_cnt !== 0) begin errors++; $display("FAIL cmd_only_ready got %0d exp 0", ready_cnt); end
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL cmd_only_done_pulse got %b exp 0", done); end
  endtask

  task automatic test_one_word();
    logic [127:0] bits, exp_bits; int nb, da, exp_n;
    words[0] = 16'h0000;
    new_frame(16'h8066, 8'd1);
    run_frame(100, 0, bits, nb, da);
    exp_bits = '0;
`ifdef DDR_TX_CRC_EN
    exp_n = 52; exp_bits[51:0] = {CMD_8066, D0000, CRC_0000};
`else
    exp_n = 40; exp_bits[39:0] = {CMD_8066, D0000};
`endif
    checks++;
    if (nb !== exp_n || bits !== exp_bits) begin
      errors++; $display("FAIL one_word_bits got %0d bits %h exp %0d bits %h", nb, bits, exp_n, exp_bits);
    end
    checks++;
    if (da !== exp_n + 1 || busy !== 1'b0 || line !== 1'b1) begin
      errors++; $display("FAIL one_word_done got strobe %0d busy %b line %b exp %0d 0 1", da, busy, line, exp_n + 1);
    end
    checks++;
    if (ready_cnt !== 1) begin errors++; $display("FAIL one_word_ready got %0d exp 1", ready_cnt); end
  endtask

  task automatic test_stall();
    logic [127:0] bits, exp_bits; int nb, da, exp_n, bad, rdy;
    words[0] = 16'h0000;
    new_frame(16'h8066, 8'd1);
    run_frame(20, 0, bits, nb, da);
    checks++;
    if (nb !== 20 || bits[19:0] !== CMD_8066) begin
      errors++; $display("FAIL stall_cmd_bits got %0d bits %h exp 20 bits %h", nb, bits[19:0], CMD_8066);
    end
    @(negedge clk);
    valid = 1'b0; pos = 1'b1;
    @(negedge clk);
    pos = 1'b0;
    bad = 0; rdy = 0;
    for (int c = 1; c <= 10; c++) begin
      if (c > 1) @(negedge clk);
      if (stall !== 1'b1 || line !== 1'b1) bad++;
      if (ready) rdy++;
      neg = (c == 4);
      if (c == 10) valid = 1'b1;
    end
    checks++;
    if (bad !== 0 || rdy !== 0) begin
      errors++; $display("FAIL stall_hold got %0d bad cycles %0d ready exp 0 0", bad, rdy);
    end
    @(negedge clk);
    checks++;
    if (stall !== 1'b0) begin errors++; $display("FAIL stall_release got %b exp 0", stall); end
    run_frame(100, 0, bits, nb, da);
    exp_bits = '0;
`ifdef DDR_TX_CRC_EN
    exp_n = 32; exp_bits[31:0] = {D0000, CRC_0000};
`else
    exp_n = 20; exp_bits[19:0] = D0000;
`endif
    checks++;
    if (nb !== exp_n || bits !== exp_bits || da !== exp_n + 1) begin
      errors++; $display("FAIL stall_tail got %0d bits %h done %0d exp %0d bits %h", nb, bits, da, exp_n, exp_bits);
    end
  endtask

  task automatic test_abort();
    logic [127:0] bits, exp_bits; int nb, da, exp_n, dn; logic b;
    words[0] = 16'h0000;
    new_frame(16'h8066, 8'd1);
    run_frame(24, 0, bits, nb, da);
    checks++;
    if (nb !== 24 || bits[23:0] !== {CMD_8066, 4'b1000}) begin
      errors++; $display("FAIL abort_pre_bits got %0d bits %h exp 24 bits %h", nb, bits[23:0], {CMD_8066, 4'b1000});
    end
    @(negedge clk);
    pos = 1'b1; abort = 1'b1;
    @(negedge clk);
    pos = 1'b0; abort = 1'b0;
    checks++;
    if ({line, busy, stall, done} !== 4'b1000) begin
      errors++; $display("FAIL abort_outputs got %b exp 1000", {line, busy, stall, done});
    end
    dn = 0;
    for (int k = 0; k < 4; k++) begin
      do_strobe(1'b0, b);
      if (done || !b) dn++;
    end
    checks++;
    if (dn !== 0) begin errors++; $display("FAIL abort_quiet got %0d events exp 0", dn); end
    new_frame(16'h8066, 8'd1);
    run_frame(100, 0, bits, nb, da);
    exp_bits = '0;
`ifdef DDR_TX_CRC_EN
    exp_n = 52; exp_bits[51:0] = {CMD_8066, D0000, CRC_0000};
`else
    exp_n = 40; exp_bits[39:0] = {CMD_8066, D0000};
`endif
    checks++;
    if (nb !== exp_n || bits !== exp_bits || da !== exp_n + 1) begin
      errors++; $display("FAIL abort_restart got %0d bits %h done %0d exp %0d bits %h", nb, bits, da, exp_n, exp_bits);
    end
  endtask

  task automatic test_multi_word();
    logic [127:0] bits1, bits2, exp_bits; int nb1, nb2, da, exp_n;
`ifdef DDR_TX_CRC_EN
    logic [4:0] c;
`endif
    words[0] = 16'h0002; words[1] = 16'h0001; words[2] = 16'hFFFF; words[3] = 16'h0000;
    new_frame(16'h0003, 8'd3);
    run_frame(10, 3, bits1, nb1, da);
    @(negedge clk);
    cmd = 16'hFFFF; word_cnt = 8'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    run_frame(100, 3, bits2, nb2, da);
    exp_bits = '0;
`ifdef DDR_TX_CRC_EN
    c = crc_ref(crc_ref(crc_ref(5'b11111, 16'h0002), 16'h0001), 16'hFFFF);
    exp_n = 92; exp_bits[91:0] = {CMD_0003, D0002, D0001, DFFFF, 2'b01, 4'b1100, c, 1'b1};
`else
    exp_n = 80; exp_bits[79:0] = {CMD_0003, D0002, D0001, DFFFF};
`endif
    checks++;
    if (nb1 + nb2 !== exp_n || ((bits1 << nb2) | bits2) !== exp_bits) begin
      errors++; $display("FAIL multi_bits got %0d bits %h exp %0d bits %h", nb1 + nb2, (bits1 << nb2) | bits2, exp_n, exp_bits);
    end
    checks++;
    if (da !== exp_n - 10 + 1 || ready_cnt !== 3) begin
      errors++; $display("FAIL multi_done got strobe %0d ready %0d exp %0d 3", da, ready_cnt, exp_n - 9);
    end
  endtask

  task automatic test_mid_reset();
    logic [127:0] bits; int nb, da; logic b;
    new_frame(16'h8066, 8'd0);
    run_frame(7, 0, bits, nb, da);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({line, busy, stall, ready, done} !== 5'b10000) begin
      errors++; $display("FAIL mid_reset_outputs got %b exp 10000", {line, busy, stall, ready, done});
    end
    do_strobe(1'b0, b);
    @(negedge clk); rst_n = 1'b1;
    run_frame(5, 0, bits, nb, da);
    checks++;
    if (bits[4:0] !== 5'b11111 || busy !== 1'b0 || da !== 0) begin
      errors++; $display("FAIL mid_reset_idle got bits %b busy %b done %0d exp 11111 0 0", bits[4:0], busy, da);
    end
    new_frame(16'h8066, 8'd0);
    run_frame(40, 0, bits, nb, da);
    checks++;
    if (nb !== 20 || bits[19:0] !== CMD_8066 || da !== 21) begin
      errors++; $display("FAIL mid_reset_restart got %0d bits %h done %0d exp 20 bits %h 21", nb, bits[19:0], da, CMD_8066);
    end
  endtask

  task automatic test_max_count();
    logic [127:0] bits; int nb, da, exp_n;
`ifdef DDR_TX_CRC_EN
    logic [4:0] c;
`endif
    for (int i = 0; i < 4; i++) words[i] = 16'h0000;
    new_frame(16'h8066, 8'd255);
    run_frame(6000, 0, bits, nb, da);
`ifdef DDR_TX_CRC_EN
    exp_n = 20 + 255 * 20 + 12;
    c = 5'b11111;
    for (int i = 0; i < 255; i++) c = crc_ref(c, 16'h0000);
    checks++;
    if (bits[11:0] !== {2'b01, 4'b1100, c, 1'b1}) begin
      errors++; $display("FAIL max_crc got %b exp %b", bits[11:0], {2'b01, 4'b1100, c, 1'b1});
    end
`else
    exp_n = 20 + 255 * 20;
`endif
    checks++;
    if (nb !== exp_n || da !== exp_n + 1 || ready_cnt !== 255) begin
      errors++; $display("FAIL max_count got bits %0d done %0d ready %0d exp %0d %0d 255", nb, da, ready_cnt, exp_n, exp_n + 1);
    end
  endtask

  initial begin
    test_reset();
    test_cmd_only();
    test_one_word();
    test_stall();
    test_abort();
    test_multi_word();
    test_mid_reset();
    test_max_count();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog expired before the end of the test sequence");
    $fatal(1, "watchdog");
  end

endmodule
